// File: rtl/timer32_core.sv
//----------------------------------------------------------------------------
// timer32_core
//
// 32-bit prescaled up-counter with compare-reload and sticky overflow flag.
// This is the counting engine behind the APB TIMER32 register wrapper. The
// wrapper supplies PRE/TMRCMP/TMREN/TMROVCLR from its registers and reads
// back TMR/TMROV (TMROV is also gated into the wrapper's IRQ).
//
// Optional feature macro: TIMER32_ONESHOT_EN
//   Defined   : ONESHOT port present; with ONESHOT=1 the counter stops at 0
//               after the first match until TMREN is sampled low.
//   Undefined : no ONESHOT port, always periodic auto-reload.
//
// Ports
//   PCLK      in   1   clock, all state on rising edge
//   PRESETn   in   1   asynchronous active-low reset
//   PRE       in  32   prescaler limit: one tick every PRE+1 enabled cycles
//   TMRCMP    in  32   compare/reload value: period is TMRCMP+1 ticks
//   TMREN     in   1   counter enable (level)
//   TMROVCLR  in   1   overflow clear (level), dominates a same-cycle match
//   ONESHOT   in   1   one-shot select (TIMER32_ONESHOT_EN only)
//   TMR       out 32   current counter value (registered)
//   TMROV     out  1   sticky compare-match flag (registered)
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module timer32_core (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PRE,
  input  logic [31:0] TMRCMP,
  input  logic        TMREN,
  input  logic        TMROVCLR,
`ifdef TIMER32_ONESHOT_EN
  input  logic        ONESHOT,
`endif
  output logic [31:0] TMR,
  output logic        TMROV
);

  logic [31:0] pre_cnt_reg, pre_cnt_next;
  logic [31:0] tmr_reg,     tmr_next;
  logic        tmrov_reg,   tmrov_next;
  logic        tick;
  logic        match;
  logic        hold;

`ifdef TIMER32_ONESHOT_EN
  logic        done_reg, done_next;

  // A completed one-shot parks the prescaler and counter until TMREN drops.
  always_comb begin
    hold = done_reg;
  end
`else
  always_comb begin
    hold = 1'b0;
  end
`endif

  // Tick is combinational from pre_cnt so the counter moves in the same
  // cycle the prescaler wraps; with PRE=0 this ticks on every enabled edge.
  // Using >= means a PRE lowered below pre_cnt wraps immediately.
  always_comb begin
    tick = TMREN && !hold && (pre_cnt_reg >= PRE);
  end

  // >= rather than == so lowering TMRCMP under the live count reloads on
  // the next tick instead of running all the way round through 32'hFFFFFFFF.
  always_comb begin
    match = tick && (tmr_reg >= TMRCMP);
  end

  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    if (!TMREN || hold) begin
      pre_cnt_next = 32'd0;
    end else if (tick) begin
      pre_cnt_next = 32'd0;
    end else begin
      pre_cnt_next = pre_cnt_reg + 32'd1;
    end
  end

  // Disabling freezes TMR; only the prescaler restarts on re-enable.
  always_comb begin
    tmr_next = tmr_reg;
    if (hold) begin
      tmr_next = 32'd0;
    end else if (tick) begin
      if (match) begin
        tmr_next = 32'd0;
      end else begin
        tmr_next = tmr_reg + 32'd1;
      end
    end
  end

  // Clear wins over a simultaneous match.
  always_comb begin
    tmrov_next = tmrov_reg;
    if (TMROVCLR) begin
      tmrov_next = 1'b0;
    end else if (match) begin
      tmrov_next = 1'b1;
    end
  end

`ifdef TIMER32_ONESHOT_EN
  // ONESHOT is looked at only on the matching tick, so toggling it
  // mid-count affects just the next match.
  always_comb begin
    done_next = done_reg;
    if (!TMREN) begin
      done_next = 1'b0;
    end else if (match && ONESHOT) begin
      done_next = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt_reg <= 32'd0;
      tmr_reg     <= 32'd0;
      tmrov_reg   <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      tmr_reg     <= tmr_next;
      tmrov_reg   <= tmrov_next;
    end
  end

  assign TMR   = tmr_reg;
  assign TMROV = tmrov_reg;

endmodule
